// File: rtl/cpu_loader.sv
// Byte-stream loader: writes imem/dmem, reads dmem back, starts/stops the CPU. Write pulse 1 cycle after the last data byte;
// first readback byte 3 cycles after the last address byte. in_ready only while collecting a command; readback waits on out_ready indefinitely.
module cpu_loader #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [31:0] addr_ext,
    output logic [31:0] wdata_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    input  logic [31:0] rdata_ext,
    output logic [31:0] addr_ext_2,
    output logic [31:0] wdata_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    input  logic [31:0] rdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        err
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_ADDR = 3'd1;
    localparam logic [2:0] S_GET_DATA = 3'd2;
    localparam logic [2:0] S_WRITE    = 3'd3;
    localparam logic [2:0] S_RD_REQ   = 3'd4;
    localparam logic [2:0] S_RD_WAIT  = 3'd5;
    localparam logic [2:0] S_SEND     = 3'd6;

    localparam logic [1:0] OP_IMEM = 2'd1;
    localparam logic [1:0] OP_DMEM = 2'd2;
    localparam logic [1:0] OP_RD   = 2'd3;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [2:0]    state;
    logic [1:0]    op;
    logic [1:0]    bcnt;
    logic [TW-1:0] tcnt;
    logic [31:0]   a_sh;
    logic [31:0]   d_sh;
    logic [31:0]   rd_sh;
    logic          ready_en;
    logic          take;
    logic          xfer;
    logic          last;
    logic          tmo;
    logic          unused;

    // Instruction memory is write-only from the loader.
    assign unused   = ^rdata_ext;
    assign ren_ext  = 1'b0;

    assign in_ready  = ready_en && (state == S_IDLE || state == S_GET_ADDR || state == S_GET_DATA);
    assign out_valid = (state == S_SEND);
    assign out_data  = rd_sh[31:24];
    assign busy      = (state != S_IDLE);
    assign wen_ext   = (state == S_WRITE) && (op == OP_IMEM);
    assign wen_ext_2 = (state == S_WRITE) && (op == OP_DMEM);
    assign ren_ext_2 = (state == S_RD_REQ) || (state == S_RD_WAIT);

    assign take = in_valid && in_ready;
    assign xfer = out_valid && out_ready;
    assign last = (bcnt == 2'd3);
    assign tmo  = (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= S_IDLE;
            op          <= 2'd0;
            bcnt        <= 2'd0;
            tcnt        <= '0;
            a_sh        <= 32'd0;
            d_sh        <= 32'd0;
            rd_sh       <= 32'd0;
            ready_en    <= 1'b0;
            addr_ext    <= 32'd0;
            wdata_ext   <= 32'd0;
            addr_ext_2  <= 32'd0;
            wdata_ext_2 <= 32'd0;
            cpu_enable  <= 1'b0;
            err         <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                S_IDLE: begin
                    bcnt <= 2'd0;
                    tcnt <= '0;
                    if (take) begin
                        case (in_data)
                            8'h01, 8'h02, 8'h03: begin
                                op    <= in_data[1:0];
                                state <= S_GET_ADDR;
                            end
                            8'h04:   cpu_enable <= 1'b1;
                            8'h05:   cpu_enable <= 1'b0;
                            8'h06:   err        <= 1'b0;
                            default: err        <= 1'b1;
                        endcase
                    end
                end
                S_GET_ADDR: begin
                    if (take) begin
                        a_sh <= {a_sh[23:0], in_data};
                        bcnt <= bcnt + 2'd1;
                        tcnt <= '0;
                        if (last) begin
                            if (op != OP_RD) begin
                                state <= S_GET_DATA;
                            end else if (cpu_enable) begin
                                err   <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                addr_ext_2 <= {a_sh[23:0], in_data};
                                state      <= S_RD_REQ;
                            end
                        end
                    end else if (tmo) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_GET_DATA: begin
                    if (take) begin
                        d_sh <= {d_sh[23:0], in_data};
                        bcnt <= bcnt + 2'd1;
                        tcnt <= '0;
                        if (last) begin
                            // A running CPU owns the memories: swallow the payload, flag it.
                            if (cpu_enable) begin
                                err   <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                if (op == OP_IMEM) begin
                                    addr_ext  <= a_sh;
                                    wdata_ext <= {d_sh[23:0], in_data};
                                end else begin
                                    addr_ext_2  <= a_sh;
                                    wdata_ext_2 <= {d_sh[23:0], in_data};
                                end
                                state <= S_WRITE;
                            end
                        end
                    end else if (tmo) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_WRITE:  state <= S_IDLE;
                S_RD_REQ: state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    rd_sh <= rdata_ext_2;
                    bcnt  <= 2'd0;
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (xfer) begin
                        rd_sh <= {rd_sh[23:0], 8'h00};
                        bcnt  <= bcnt + 2'd1;
                        if (last) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_loader.sv
// Bench for cpu_loader: directed scenarios plus random command streams, scored against a command-level model.
`timescale 1ns/1ps
module tb_cpu_loader;
    localparam int TO = 24;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [7:0]  out_data;
    logic [31:0] addr_ext, wdata_ext, rdata_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, busy, err;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign rdata_ext = 32'h5A5A_A5A5;

    cpu_loader #(.TIMEOUT(TO)) dut (
        .clk(clk), .arst_n(arst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .addr_ext(addr_ext), .wdata_ext(wdata_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wdata_ext_2(wdata_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .rdata_ext_2(rdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .err(err)
    );

    // Data memory: registered read, one cycle after ren.
    logic [31:0] dmem [bit [31:0]];
    always @(posedge clk) begin
        if (wen_ext_2) dmem[addr_ext_2] = wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem.exists(addr_ext_2) ? dmem[addr_ext_2] : 32'h0;
    end

    // Command-level reference model.
    bit [31:0]   ref_mem [bit [31:0]];
    bit          ref_en = 1'b0;
    bit          ref_err = 1'b0;
    logic [63:0] exp_imem_q[$];
    logic [63:0] exp_dmem_q[$];
    logic [7:0]  exp_out_q[$];
    bit          ren_seen = 1'b0;

    task automatic model_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        case (op)
            8'h01: if (ref_en) ref_err = 1'b1; else exp_imem_q.push_back({a, d});
            8'h02: if (ref_en) ref_err = 1'b1;
                   else begin exp_dmem_q.push_back({a, d}); ref_mem[a] = d; end
            8'h03: if (ref_en) ref_err = 1'b1;
                   else begin
                       w = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
                       for (int i = 3; i >= 0; i--) exp_out_q.push_back(w[i*8 +: 8]);
                   end
            8'h04: ref_en = 1'b1;
            8'h05: ref_en = 1'b0;
            8'h06: ref_err = 1'b0;
            default: ref_err = 1'b1;
        endcase
    endtask

    // Scoreboard: every write pulse and readback byte must match the next expected event.
    always @(negedge clk) begin : mon
        logic [63:0] e;
        logic [7:0]  b;
        if (ren_ext) ren_seen = 1'b1;
        if (wen_ext) begin
            n_cmp++;
            if (exp_imem_q.size() == 0) begin
                n_fail++; $display("FAIL imem_wr: observed %h/%h, required no write", addr_ext, wdata_ext);
            end else begin
                e = exp_imem_q.pop_front();
                if ({addr_ext, wdata_ext} !== e) begin
                    n_fail++; $display("FAIL imem_wr: observed %h, required %h", {addr_ext, wdata_ext}, e);
                end
            end
        end
        if (wen_ext_2) begin
            n_cmp++;
            if (exp_dmem_q.size() == 0) begin
                n_fail++; $display("FAIL dmem_wr: observed %h/%h, required no write", addr_ext_2, wdata_ext_2);
            end else begin
                e = exp_dmem_q.pop_front();
                if ({addr_ext_2, wdata_ext_2} !== e) begin
                    n_fail++; $display("FAIL dmem_wr: observed %h, required %h", {addr_ext_2, wdata_ext_2}, e);
                end
            end
        end
        if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_out_q.size() == 0) begin
                n_fail++; $display("FAIL out_byte: observed %h, required no byte", out_data);
            end else begin
                b = exp_out_q.pop_front();
                if (out_data !== b) begin
                    n_fail++; $display("FAIL out_byte: observed %h, required %h", out_data, b);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 100; n++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; n_fail++;
        $display("FAIL send_byte: in_ready stayed 0 for byte %h, required 1", b);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d, input int maxgap);
        send_byte(op, $urandom_range(0, maxgap));
        if (op == 8'h01 || op == 8'h02 || op == 8'h03)
            for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], $urandom_range(0, maxgap));
        if (op == 8'h01 || op == 8'h02)
            for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], $urandom_range(0, maxgap));
        model_cmd(op, a, d);
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (!busy) return;
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        n_cmp++; n_fail++;
        $display("FAIL drain: busy still 1 after 300 cycles, required 0");
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, busy, out_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, err} !== 9'b0) begin
            n_fail++; $display("FAIL reset_ctrl: observed %b, required 0",
                {in_ready, busy, out_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, err});
        end
        n_cmp++;
        if ({addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, out_data} !== 136'b0) begin
            n_fail++; $display("FAIL reset_data: observed %h, required 0", {addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, out_data});
        end
        #2 arst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({in_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release: in_ready/busy observed %b, required 10", {in_ready, busy});
        end
    endtask

    task automatic test_imem_write();
        send_cmd(8'h01, 32'h4, 32'h3C01000A, 2);
        n_cmp++;
        if ({wen_ext, addr_ext, wdata_ext, wen_ext_2} !== {1'b1, 32'h4, 32'h3C01000A, 1'b0}) begin
            n_fail++; $display("FAIL imem_wen_latency: observed wen=%b addr=%h data=%h wen2=%b, required 1/00000004/3c01000a/0",
                wen_ext, addr_ext, wdata_ext, wen_ext_2);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({wen_ext, busy, exp_imem_q.size() == 0} !== 3'b001) begin
            n_fail++; $display("FAIL imem_wen_width: wen/busy/pending observed %b%b%0d, required 0/0/0",
                wen_ext, busy, exp_imem_q.size());
        end
    endtask

    task automatic test_dmem_read();
        send_cmd(8'h02, 32'h10, 32'hDEADBEEF, 2);
        drain();
        out_ready = 1'b0;
        send_cmd(8'h03, 32'h10, 32'h0, 2);
        n_cmp++;
        if ({out_valid, ren_ext_2, addr_ext_2} !== {1'b0, 1'b1, 32'h10}) begin
            n_fail++; $display("FAIL rd_req: observed valid=%b ren=%b addr=%h, required 0/1/00000010", out_valid, ren_ext_2, addr_ext_2);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, ren_ext_2} !== 2'b01) begin
            n_fail++; $display("FAIL rd_wait: observed valid/ren %b, required 01", {out_valid, ren_ext_2});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, out_data, ren_ext_2} !== {1'b1, 8'hDE, 1'b0}) begin
            n_fail++; $display("FAIL rd_latency: observed valid=%b data=%h ren=%b, required 1/de/0", out_valid, out_data, ren_ext_2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, out_data} !== {1'b1, 8'hAD}) begin
                n_fail++; $display("FAIL stall_hold: cycle %0d observed valid=%b data=%h, required 1/ad", i, out_valid, out_data);
            end
            @(posedge clk); #1;
        end
        repeat (TO + 2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, out_valid, out_data} !== {1'b1, 1'b1, 8'hAD}) begin
            n_fail++; $display("FAIL send_no_timeout: observed busy=%b valid=%b data=%h, required 1/1/ad", busy, out_valid, out_data);
        end
        drain();
        n_cmp++;
        if ({exp_out_q.size() == 0, ren_seen, addr_ext} !== {1'b1, 1'b0, 32'h4}) begin
            n_fail++; $display("FAIL rd_done: observed pending=%0d ren_imem=%b addr_ext=%h, required 0/0/00000004",
                exp_out_q.size(), ren_seen, addr_ext);
        end
    endtask

    task automatic test_cpu_enable();
        send_cmd(8'h04, 32'h0, 32'h0, 1);
        n_cmp++;
        if (cpu_enable !== 1'b1) begin
            n_fail++; $display("FAIL run: cpu_enable observed %b, required 1", cpu_enable);
        end
        send_cmd(8'h02, 32'h0, 32'h11223344, 1);
        drain();
        n_cmp++;
        if ({cpu_enable, err, busy} !== {ref_en, ref_err, 1'b0}) begin
            n_fail++; $display("FAIL blocked_wr: en/err/busy observed %b, required %b", {cpu_enable, err, busy}, {ref_en, ref_err, 1'b0});
        end
        send_cmd(8'h03, 32'h10, 32'h0, 1);
        drain();
        send_cmd(8'h05, 32'h0, 32'h0, 1);
        send_cmd(8'h06, 32'h0, 32'h0, 1);
        n_cmp++;
        if ({cpu_enable, err, exp_out_q.size() == 0} !== 3'b001) begin
            n_fail++; $display("FAIL halt_clr: en/err observed %b, pending %0d, required 00 / 0", {cpu_enable, err}, exp_out_q.size());
        end
    endtask

    task automatic test_timeout();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        repeat (TO - 1) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, err} !== 2'b10) begin
            n_fail++; $display("FAIL timeout_early: busy/err observed %b, required 10", {busy, err});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, err} !== 2'b01) begin
            n_fail++; $display("FAIL timeout_abort: busy/err observed %b, required 01", {busy, err});
        end
        ref_err = 1'b1;
        send_byte(8'h01, 0);
        send_byte(8'h00, TO - 1); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h08, TO - 1);
        send_byte(8'h12, TO - 1); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, TO - 1);
        model_cmd(8'h01, 32'h8, 32'h12345678);
        n_cmp++;
        if ({wen_ext, addr_ext, wdata_ext, err} !== {1'b1, 32'h8, 32'h12345678, 1'b1}) begin
            n_fail++; $display("FAIL timeout_edge_gap: observed wen=%b addr=%h data=%h err=%b, required 1/00000008/12345678/1",
                wen_ext, addr_ext, wdata_ext, err);
        end
        drain();
    endtask

    task automatic test_bad_opcode();
        send_cmd(8'h06, 32'h0, 32'h0, 0);
        send_cmd(8'h7F, 32'h0, 32'h0, 0);
        n_cmp++;
        if ({busy, err, in_ready} !== 3'b011) begin
            n_fail++; $display("FAIL bad_opcode: busy/err/in_ready observed %b, required 011", {busy, err, in_ready});
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h01, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i), 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 arst_n = 1'b0;
        #1;
        ref_en = 1'b0; ref_err = 1'b0;
        n_cmp++;
        if ({in_ready, busy, out_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, err} !== 9'b0) begin
            n_fail++; $display("FAIL reset_mid_ctrl: observed %b, required 0",
                {in_ready, busy, out_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, err});
        end
        n_cmp++;
        if ({addr_ext, wdata_ext, addr_ext_2, wdata_ext_2} !== 128'b0) begin
            n_fail++; $display("FAIL reset_mid_data: observed %h, required 0", {addr_ext, wdata_ext, addr_ext_2, wdata_ext_2});
        end
        @(posedge clk); #3 arst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({in_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL reset_mid_release: in_ready/busy observed %b, required 10", {in_ready, busy});
        end
        send_cmd(8'h04, 32'h0, 32'h0, 0);
        #2 arst_n = 1'b0;
        #1;
        ref_en = 1'b0;
        n_cmp++;
        if (cpu_enable !== 1'b0) begin
            n_fail++; $display("FAIL reset_cpu_enable: observed %b, required 0", cpu_enable);
        end
        @(posedge clk); #3 arst_n = 1'b1;
        @(posedge clk); #1;
        send_cmd(8'h01, 32'h2C, 32'hCAFEF00D, 1);
        drain();
        n_cmp++;
        if ({exp_imem_q.size() == 0, addr_ext, wdata_ext} !== {1'b1, 32'h2C, 32'hCAFEF00D}) begin
            n_fail++; $display("FAIL reset_mid_after: pending=%0d addr=%h data=%h, required 0/0000002c/cafef00d",
                exp_imem_q.size(), addr_ext, wdata_ext);
        end
    endtask

    task automatic test_random();
        logic [7:0]  op;
        logic [31:0] a;
        int          r;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 15);
            if (r <= 2)       op = 8'h01;
            else if (r <= 5)  op = 8'h02;
            else if (r <= 9)  op = 8'h03;
            else if (r == 10) op = 8'h04;
            else if (r == 11) op = 8'h06;
            else if (r == 12) op = 8'($urandom_range(7, 255));
            else              op = 8'h05;
            a = (k % 5 == 0) ? $urandom : {27'd0, 3'($urandom_range(0, 7)), 2'b00};
            send_cmd(op, a, $urandom, 3);
            drain();
            n_cmp++;
            if ({cpu_enable, err, busy} !== {ref_en, ref_err, 1'b0}) begin
                n_fail++; $display("FAIL random_cmd %0d op %h: en/err/busy observed %b, required %b",
                    k, op, {cpu_enable, err, busy}, {ref_en, ref_err, 1'b0});
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({exp_imem_q.size() == 0, exp_dmem_q.size() == 0, exp_out_q.size() == 0, ren_seen} !== 4'b1110) begin
            n_fail++; $display("FAIL random_pending: imem=%0d dmem=%0d out=%0d ren_imem=%b, required 0/0/0/0",
                exp_imem_q.size(), exp_dmem_q.size(), exp_out_q.size(), ren_seen);
        end
    endtask

    initial begin
        test_reset();
        test_imem_write();
        test_dmem_read();
        test_cpu_enable();
        test_timeout();
        test_bad_opcode();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
